// File: rtl/rv_pkg.sv
// Shared RISC-V definitions for the decode stage: opcodes, ALU op classes
// and the control bundle carried from ID into EX.
package rv_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_BR    = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B
   } imm_sel_t;

   typedef struct packed {
      logic       branch;
      logic       mem_read;
      logic       mem_to_reg;
      logic       mem_write;
      logic       alu_src;
      logic       reg_write;
      logic [1:0] alu_op;
   } ctrl_t;

   // Opcodes that actually consume rs2; only these can create an rs2 hazard.
   function automatic logic uses_rs2(input logic [6:0] opcode);
      return (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
   endfunction

endpackage

// File: rtl/decode_stage_hz_regfile_bypass.sv
// Two-read / one-write register file; a same-cycle writeback to the
// addressed register is forwarded straight to the read port.
module regfile_bypass
   import rv_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [XLEN-1:0]   wdata,
   input  logic [REG_AW-1:0] raddr1,
   input  logic [REG_AW-1:0] raddr2,
   output logic [XLEN-1:0]   rdata1,
   output logic [XLEN-1:0]   rdata2
);

   localparam int NREGS = 2 ** REG_AW;

   logic [XLEN-1:0] regs [NREGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   // Entry 0 is forced to zero on read as well, so a bypass can never leak into x0.
   always_comb begin
      rdata1 = regs[raddr1];
      if (raddr1 == '0) begin
         rdata1 = '0;
      end else if (we && (waddr == raddr1)) begin
         rdata1 = wdata;
      end
   end

   always_comb begin
      rdata2 = regs[raddr2];
      if (raddr2 == '0) begin
         rdata2 = '0;
      end else if (we && (waddr == raddr2)) begin
         rdata2 = wdata;
      end
   end

endmodule

// File: rtl/decode_stage_hz.sv
// Decode stage with integrated register file, load-use hazard stall,
// flush/hold control of ID/EX, and a saturating stall-cycle counter.
module decode_stage_hz
   import rv_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       InstrD,
   input  logic [XLEN-1:0]   PCD,
   input  logic              ValidD,
   input  logic              RegWriteW,
   input  logic [REG_AW-1:0] Write_reg,
   input  logic [XLEN-1:0]   WriteDataW,
   input  logic              FlushE,
   input  logic              HoldE,
   output logic              StallD,
   output logic              ValidE,
   output logic              BranchE,
   output logic              MemReadE,
   output logic              MemtoRegE,
   output logic              MemWriteE,
   output logic              ALUSrcE,
   output logic              RegWriteE,
   output logic [1:0]        ALUOpE,
   output logic [XLEN-1:0]   PCE,
   output logic [XLEN-1:0]   ReadData1E,
   output logic [XLEN-1:0]   ReadData2E,
   output logic [XLEN-1:0]   immediateE,
   output logic [31:0]       InstrE,
   output logic [CNT_W-1:0]  StallCount
);

   logic [6:0]        opcode;
   logic [REG_AW-1:0] rs1;
   logic [REG_AW-1:0] rs2;
   logic [REG_AW-1:0] rd_e;
   logic [XLEN-1:0]   rdata1;
   logic [XLEN-1:0]   rdata2;
   logic [XLEN-1:0]   imm_i;
   logic [XLEN-1:0]   imm_s;
   logic [XLEN-1:0]   imm_b;
   logic [XLEN-1:0]   imm_d;
   imm_sel_t          imm_sel;
   ctrl_t             ctrl_d;
   ctrl_t             ctrl_e;
   logic              hazard;

   assign opcode = InstrD[6:0];
   assign rs1    = REG_AW'(InstrD[19:15]);
   assign rs2    = REG_AW'(InstrD[24:20]);
   assign rd_e   = REG_AW'(InstrE[11:7]);

   regfile_bypass #(
      .XLEN   (XLEN),
      .REG_AW (REG_AW)
   ) u_regfile (
      .clk    (clk),
      .rst    (rst),
      .we     (RegWriteW),
      .waddr  (Write_reg),
      .wdata  (WriteDataW),
      .raddr1 (rs1),
      .raddr2 (rs2),
      .rdata1 (rdata1),
      .rdata2 (rdata2)
   );

   assign imm_i = XLEN'($signed(InstrD[31:20]));
   assign imm_s = XLEN'($signed({InstrD[31:25], InstrD[11:7]}));
   assign imm_b = XLEN'($signed({InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0}));

   always_comb begin
      ctrl_d  = '0;
      imm_sel = IMM_NONE;
      case (opcode)
         OP_R: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_op    = ALUOP_FUNCT;
         end
         OP_IMM: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.alu_op    = ALUOP_FUNCT;
            imm_sel          = IMM_I;
         end
         OP_LOAD: begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.mem_read   = 1'b1;
            ctrl_d.mem_to_reg = 1'b1;
            ctrl_d.alu_src    = 1'b1;
            ctrl_d.alu_op     = ALUOP_ADD;
            imm_sel           = IMM_I;
         end
         OP_STORE: begin
            ctrl_d.mem_write = 1'b1;
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.alu_op    = ALUOP_ADD;
            imm_sel          = IMM_S;
         end
         OP_BRANCH: begin
            ctrl_d.branch = 1'b1;
            ctrl_d.alu_op = ALUOP_BR;
            imm_sel       = IMM_B;
         end
         default: begin
            ctrl_d  = '0;
            imm_sel = IMM_NONE;
         end
      endcase
   end

   always_comb begin
      case (imm_sel)
         IMM_I:   imm_d = imm_i;
         IMM_S:   imm_d = imm_s;
         IMM_B:   imm_d = imm_b;
         default: imm_d = '0;
      endcase
   end

   // A load in EX whose destination is read by the instruction in ID.
   assign hazard = ValidE && ctrl_e.mem_read && (rd_e != '0) && ValidD &&
                   ((rd_e == rs1) || ((rd_e == rs2) && uses_rs2(opcode)));

   assign StallD = hazard && !FlushE && !HoldE;

   // Hold outranks flush: a flush requested during a hold lands once the hold drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         ValidE     <= 1'b0;
         ctrl_e     <= '0;
         PCE        <= '0;
         ReadData1E <= '0;
         ReadData2E <= '0;
         immediateE <= '0;
         InstrE     <= '0;
      end else if (HoldE) begin
         ValidE     <= ValidE;
         ctrl_e     <= ctrl_e;
         PCE        <= PCE;
         ReadData1E <= ReadData1E;
         ReadData2E <= ReadData2E;
         immediateE <= immediateE;
         InstrE     <= InstrE;
      end else if (FlushE || hazard) begin
         ValidE     <= 1'b0;
         ctrl_e     <= '0;
         PCE        <= '0;
         ReadData1E <= '0;
         ReadData2E <= '0;
         immediateE <= '0;
         InstrE     <= '0;
      end else begin
         ValidE     <= ValidD;
         ctrl_e     <= ValidD ? ctrl_d : '0;
         PCE        <= PCD;
         ReadData1E <= rdata1;
         ReadData2E <= rdata2;
         immediateE <= imm_d;
         InstrE     <= InstrD;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         StallCount <= '0;
      end else if (StallD && (StallCount != '1)) begin
         StallCount <= StallCount + CNT_W'(1);
      end
   end

   assign BranchE   = ctrl_e.branch;
   assign MemReadE  = ctrl_e.mem_read;
   assign MemtoRegE = ctrl_e.mem_to_reg;
   assign MemWriteE = ctrl_e.mem_write;
   assign ALUSrcE   = ctrl_e.alu_src;
   assign RegWriteE = ctrl_e.reg_write;
   assign ALUOpE    = ctrl_e.alu_op;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Self-checking bench for decode_stage_hz: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_decode_stage_hz;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int CNT_W  = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic [31:0]       InstrD;
   logic [XLEN-1:0]   PCD;
   logic              ValidD;
   logic              RegWriteW;
   logic [REG_AW-1:0] Write_reg;
   logic [XLEN-1:0]   WriteDataW;
   logic              FlushE;
   logic              HoldE;
   logic              StallD;
   logic              ValidE, BranchE, MemReadE, MemtoRegE, MemWriteE, ALUSrcE, RegWriteE;
   logic [1:0]        ALUOpE;
   logic [XLEN-1:0]   PCE, ReadData1E, ReadData2E, immediateE;
   logic [31:0]       InstrE;
   logic [CNT_W-1:0]  StallCount;

   decode_stage_hz #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .ValidD(ValidD),
      .RegWriteW(RegWriteW), .Write_reg(Write_reg), .WriteDataW(WriteDataW),
      .FlushE(FlushE), .HoldE(HoldE), .StallD(StallD), .ValidE(ValidE),
      .BranchE(BranchE), .MemReadE(MemReadE), .MemtoRegE(MemtoRegE),
      .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE), .RegWriteE(RegWriteE),
      .ALUOpE(ALUOpE), .PCE(PCE), .ReadData1E(ReadData1E), .ReadData2E(ReadData2E),
      .immediateE(immediateE), .InstrE(InstrE), .StallCount(StallCount)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        valid;
      logic        branch;
      logic        mem_read;
      logic        mem_to_reg;
      logic        mem_write;
      logic        alu_src;
      logic        reg_write;
      logic [1:0]  alu_op;
      logic [31:0] pc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] instr;
   } estate_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_regs [32];
   estate_t     m_e;
   int          m_cnt;
   bit          known = 0;
   logic        last_stall;

   // Instruction encodings used by the directed scenarios.
   localparam logic [31:0] ADD_X1_X5_X0 = {7'd0, 5'd0, 5'd5, 3'd0, 5'd1, 7'b0110011};
   localparam logic [31:0] ADD_X1_X0_X0 = {7'd0, 5'd0, 5'd0, 3'd0, 5'd1, 7'b0110011};
   localparam logic [31:0] LW_X3_X2     = {12'd0, 5'd2, 3'b010, 5'd3, 7'b0000011};
   localparam logic [31:0] ADD_X4_X3_X1 = {7'd0, 5'd1, 5'd3, 3'd0, 5'd4, 7'b0110011};
   localparam logic [31:0] ADDI_X4_X1_3 = {12'd3, 5'd1, 3'd0, 5'd4, 7'b0010011};
   localparam logic [31:0] SW_X2_X1     = {7'd0, 5'd2, 5'd1, 3'b010, 5'd8, 7'b0100011};
   localparam logic [31:0] BEQ_M4       = {1'b1, 6'b111111, 5'd2, 5'd1, 3'd0, 4'b1110, 1'b1, 7'b1100011};
   localparam logic [31:0] SW_7FF       = {7'b0111111, 5'd2, 5'd1, 3'b010, 5'b11111, 7'b0100011};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   // Spec-level decode: controls and sign-extended immediate per opcode.
   function automatic estate_t modelDecode(input logic [31:0] i);
      estate_t d = '0;
      case (i[6:0])
         7'h33: begin d.reg_write = 1; d.alu_op = 2'd2; end
         7'h13: begin d.reg_write = 1; d.alu_src = 1; d.alu_op = 2'd2;
                      d.imm = {{20{i[31]}}, i[31:20]}; end
         7'h03: begin d.reg_write = 1; d.mem_read = 1; d.mem_to_reg = 1; d.alu_src = 1;
                      d.imm = {{20{i[31]}}, i[31:20]}; end
         7'h23: begin d.mem_write = 1; d.alu_src = 1;
                      d.imm = {{20{i[31]}}, i[31:25], i[11:7]}; end
         7'h63: begin d.branch = 1; d.alu_op = 2'd1;
                      d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; end
         default: d = '0;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] modelRead(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
      if (a == 0) return 32'd0;
      if (we && wa == a) return wd;
      return m_regs[a];
   endfunction

   task automatic checkOutput();
      check("ValidE", {31'd0, ValidE}, {31'd0, m_e.valid});
      check("BranchE", {31'd0, BranchE}, {31'd0, m_e.branch});
      check("MemReadE", {31'd0, MemReadE}, {31'd0, m_e.mem_read});
      check("MemtoRegE", {31'd0, MemtoRegE}, {31'd0, m_e.mem_to_reg});
      check("MemWriteE", {31'd0, MemWriteE}, {31'd0, m_e.mem_write});
      check("ALUSrcE", {31'd0, ALUSrcE}, {31'd0, m_e.alu_src});
      check("RegWriteE", {31'd0, RegWriteE}, {31'd0, m_e.reg_write});
      check("ALUOpE", {30'd0, ALUOpE}, {30'd0, m_e.alu_op});
      check("PCE", PCE, m_e.pc);
      check("ReadData1E", ReadData1E, m_e.rd1);
      check("ReadData2E", ReadData2E, m_e.rd2);
      check("immediateE", immediateE, m_e.imm);
      check("InstrE", InstrE, m_e.instr);
      check("StallCount", {28'd0, StallCount}, m_cnt);
   endtask

   // One clock cycle: drive inputs, check StallD, advance the model, check E outputs.
   task automatic applyStimulus(input logic r, input logic [31:0] instr, input logic [31:0] pc,
                                input logic v, input logic rw, input logic [4:0] wa,
                                input logic [31:0] wd, input logic fl, input logic ho);
      estate_t     dec, nxt;
      logic [4:0]  rs1, rs2, rde;
      logic        hz, stall, uses2;
      int          nxt_cnt;
      @(negedge clk);
      rst = r; InstrD = instr; PCD = pc; ValidD = v; RegWriteW = rw;
      Write_reg = wa; WriteDataW = wd; FlushE = fl; HoldE = ho;
      #1;
      rs1   = instr[19:15];
      rs2   = instr[24:20];
      rde   = m_e.instr[11:7];
      uses2 = (instr[6:0] == 7'h33) || (instr[6:0] == 7'h23) || (instr[6:0] == 7'h63);
      hz    = m_e.valid && m_e.mem_read && rde != 0 && v && (rde == rs1 || (rde == rs2 && uses2));
      stall = hz && !fl && !ho;
      last_stall = StallD;
      if (known && !r) check("StallD", {31'd0, StallD}, {31'd0, stall});
      dec       = modelDecode(instr);
      dec.valid = v;
      dec.pc    = pc;
      dec.rd1   = modelRead(rs1, rw, wa, wd);
      dec.rd2   = modelRead(rs2, rw, wa, wd);
      dec.instr = instr;
      if (!v) {dec.branch, dec.mem_read, dec.mem_to_reg, dec.mem_write,
                dec.alu_src, dec.reg_write, dec.alu_op} = '0;
      if (ho)           nxt = m_e;
      else if (fl || hz) nxt = '0;
      else              nxt = dec;
      nxt_cnt = (stall && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
      @(posedge clk);
      #1;
      if (r) begin
         m_e = '0; m_cnt = 0; known = 1;
         for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
      end else begin
         if (rw && wa != 0) m_regs[wa] = wd;
         m_e = nxt; m_cnt = nxt_cnt;
      end
      if (known) checkOutput();
   endtask

   task automatic idle(input logic [31:0] instr, input logic v);
      applyStimulus(0, instr, $urandom, v, 0, 0, 0, 0, 0);
   endtask

   function automatic logic [31:0] randInstr();
      logic [31:0] i = $urandom;
      logic [6:0]  ops [6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h7F};
      i[6:0]   = ops[$urandom_range(0, 5)];
      i[11:7]  = 5'($urandom_range(0, 7));
      i[19:15] = 5'($urandom_range(0, 7));
      i[24:20] = 5'($urandom_range(0, 7));
      return i;
   endfunction

   initial begin
      rst = 1; InstrD = 0; PCD = 0; ValidD = 0; RegWriteW = 0;
      Write_reg = 0; WriteDataW = 0; FlushE = 0; HoldE = 0;

      // Reset with random inputs.
      for (int k = 0; k < 2; k++)
         applyStimulus(1, $urandom, $urandom, 1, 1, 5'($urandom), $urandom, $urandom_range(0,1), 0);
      check("rst_ValidE", {31'd0, ValidE}, 32'd0);
      check("rst_StallCount", {28'd0, StallCount}, 32'd0);
      check("rst_StallD", {31'd0, StallD}, 32'd0);
      idle(ADD_X1_X5_X0, 1);
      check("rst_x5_read", ReadData1E, 32'd0);

      // Writeback bypass and x0 write suppression.
      applyStimulus(0, ADD_X1_X5_X0, 32'h100, 1, 1, 5'd5, 32'hDEADBEEF, 0, 0);
      check("bypass_rd1", ReadData1E, 32'hDEADBEEF);
      idle(ADD_X1_X5_X0, 1);
      check("stored_rd1", ReadData1E, 32'hDEADBEEF);
      applyStimulus(0, ADD_X1_X0_X0, 32'h104, 1, 1, 5'd0, 32'h12345678, 0, 0);
      check("x0_bypass", ReadData1E, 32'd0);
      idle(ADD_X1_X0_X0, 1);
      check("x0_stored", ReadData1E, 32'd0);

      // Load-use: one stall, one bubble, then the consumer enters EX.
      idle(LW_X3_X2, 1);
      check("lw_MemReadE", {31'd0, MemReadE}, 32'd1);
      idle(ADD_X4_X3_X1, 1);
      check("lu_StallD", {31'd0, last_stall}, 32'd1);
      check("lu_bubble_ValidE", {31'd0, ValidE}, 32'd0);
      check("lu_bubble_RegWriteE", {31'd0, RegWriteE}, 32'd0);
      check("lu_StallCount", {28'd0, StallCount}, 32'd1);
      idle(ADD_X4_X3_X1, 1);
      check("lu_resolved_StallD", {31'd0, last_stall}, 32'd0);
      check("lu_add_InstrE", InstrE, ADD_X4_X3_X1);
      check("lu_add_ValidE", {31'd0, ValidE}, 32'd1);

      // I-type with x3 only in the rs2 field must not stall.
      idle(LW_X3_X2, 1);
      idle(ADDI_X4_X1_3, 1);
      check("itype_no_stall", {31'd0, last_stall}, 32'd0);

      // Flush of a store, and flush masking a hazard stall.
      applyStimulus(0, SW_X2_X1, 32'h200, 1, 0, 0, 0, 1, 0);
      check("flush_ValidE", {31'd0, ValidE}, 32'd0);
      check("flush_MemWriteE", {31'd0, MemWriteE}, 32'd0);
      idle(LW_X3_X2, 1);
      applyStimulus(0, ADD_X4_X3_X1, 32'h204, 1, 0, 0, 0, 1, 0);
      check("flush_masks_stall", {31'd0, last_stall}, 32'd0);

      // Hold keeps contents; a flush during hold lands after hold drops.
      idle(LW_X3_X2, 1);
      for (int k = 0; k < 3; k++)
         applyStimulus(0, randInstr(), $urandom, 1, 0, 0, 0, 0, 1);
      check("hold_InstrE", InstrE, LW_X3_X2);
      for (int k = 0; k < 2; k++)
         applyStimulus(0, randInstr(), $urandom, 1, 0, 0, 0, 1, 1);
      check("holdflush_InstrE", InstrE, LW_X3_X2);
      check("holdflush_ValidE", {31'd0, ValidE}, 32'd1);
      applyStimulus(0, ADD_X1_X0_X0, 32'h300, 1, 0, 0, 0, 1, 0);
      check("flush_after_hold", {31'd0, ValidE}, 32'd0);

      // Immediate formats and the unknown opcode.
      idle(BEQ_M4, 1);
      check("beq_imm", immediateE, 32'hFFFFFFFC);
      check("beq_BranchE", {31'd0, BranchE}, 32'd1);
      check("beq_ALUOpE", {30'd0, ALUOpE}, 32'd1);
      idle(SW_7FF, 1);
      check("sw_imm", immediateE, 32'h000007FF);
      idle(32'hFFFFFFFF, 1);
      check("unk_imm", immediateE, 32'd0);
      check("unk_RegWriteE", {31'd0, RegWriteE}, 32'd0);

      // Randomized traffic; long enough to drive the stall counter into saturation.
      for (int k = 0; k < 600; k++) begin
         applyStimulus(0, randInstr(), $urandom, ($urandom_range(0, 9) != 0),
                       $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                       ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
      end
      for (int k = 0; k < 40; k++) begin
         idle(LW_X3_X2, 1);
         idle(ADD_X4_X3_X1, 1);
         idle(ADD_X4_X3_X1, 1);
      end
      check("sat_StallCount", {28'd0, StallCount}, CNT_MAX);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_stage_hz.md
Name: decode_stage_hz

Overview:
- Parametrised successor to the current decode stage of the pipelined RISC-V core; sits between the IF/ID and EX stages.
- Decodes InstrD into control signals and an immediate, and reads the integrated register file.
- Registers everything into the ID/EX pipeline register.
- New behaviour:
  - load-use hazard detection that stalls fetch and inserts a bubble;
  - flush and hold control of the ID/EX register;
  - write-through register bypass;
  - a valid bit;
  - a saturating stall counter.

Parameters:
XLEN, 32, datapath width (immediates sign-extended to XLEN)
REG_AW, 5, register address width; register file holds 2**REG_AW entries, entry 0 reads zero
CNT_W, 16, width of the stall counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
InstrD  in  32  instruction from IF/ID
PCD  in  XLEN  PC of InstrD
ValidD  in  1  InstrD is a real instruction
RegWriteW  in  1  writeback enable
Write_reg  in  REG_AW  writeback address
WriteDataW  in  XLEN  writeback data
FlushE  in  1  branch taken in EX; kill instruction entering EX
HoldE  in  1  downstream freeze; ID/EX register keeps contents
StallD  out  1  hazard stall to fetch (hold PC and IF/ID)
ValidE, BranchE, MemReadE, MemtoRegE, MemWriteE, ALUSrcE, RegWriteE  out  1 each  registered controls
ALUOpE  out  2  registered ALU op class
PCE, ReadData1E, ReadData2E, immediateE  out  XLEN  registered data
InstrE  out  32  registered instruction
StallCount  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset: while rst=1 at a clock edge:
  - all E outputs cleared to 0 (ValidE=0);
  - all registers x0..xN cleared to 0;
  - StallCount cleared to 0.
  - StallD is combinational; it stays 0 while ValidE=0 after reset.
- Decode (combinational on InstrD). Opcodes map as follows, with ALUOp encoded 00 add / 01 branch-compare / 10 funct-decoded:
  - 0110011 R: RegWrite, ALUOp=10.
  - 0010011 I-ALU: RegWrite, ALUSrc, ALUOp=10, imm=I.
  - 0000011 load: RegWrite, MemRead, MemtoReg, ALUSrc, ALUOp=00, imm=I.
  - 0100011 store: MemWrite, ALUSrc, ALUOp=00, imm=S.
  - 1100011 branch: Branch, ALUOp=01, imm=B (bit0=0).
  - Any other opcode: all controls 0, imm=0.
  - All immediates are sign-extended to XLEN.
- Register file:
  - Rising-edge write when RegWriteW=1 and Write_reg!=0; writes to entry 0 are ignored.
  - Reads are combinational on rs1=InstrD[19:15], rs2=InstrD[24:20], truncated to REG_AW.
  - Write-through: if RegWriteW=1, Write_reg==rs and rs!=0, read data = WriteDataW in the same cycle.
- Hazard detection:
  - Hazard = ValidE & MemReadE & rdE!=0 & ValidD & (rdE==rs1 | (rdE==rs2 & opcode in {R, store, branch})).
  - rdE = InstrE[11:7] truncated.
  - StallD = Hazard & ~FlushE & ~HoldE.
- ID/EX register update priority (one-cycle latency):
  1. rst: clear.
  2. HoldE: keep all contents; no other update happens.
  3. FlushE: bubble — ValidE=0, all controls 0; data fields don't-care, but implementation drives 0.
  4. Hazard: bubble, same as 3.
  5. Otherwise: load decoded values; ValidE=ValidD, and controls are ANDed with ValidD.
- HoldE with FlushE: flush is ignored while HoldE=1. The requester keeps FlushE asserted until HoldE drops.
- Register-file writes occur regardless of HoldE, FlushE or stall.
- StallCount increments on each edge where StallD=1 and saturates at all-ones.
- A stalled load-use pair resolves after exactly one bubble: the load advances and ValidE for the bubble is 0, so Hazard deasserts.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH);
  - ALUOp encodings (ALUOP_ADD, ALUOP_BR, ALUOP_FUNCT);
  - the default XLEN.
- One sub-module, regfile_bypass: parametrised XLEN/REG_AW, synchronous reset, two read ports with write-through, one write port.
- Decode, immediate generation, hazard logic and the pipeline register stay in decode_stage_hz.

Test Plan:
- Reset: hold rst=1 two cycles with random inputs -> all E outputs 0, StallD=0, StallCount=0; read of x5 returns 0.
- Writeback bypass: RegWriteW=1, Write_reg=5, WriteDataW=0xDEADBEEF, InstrD=add x1,x5,x0 -> next cycle ReadData1E=0xDEADBEEF. Write to x0 -> ReadData of x0 stays 0.
- Load-use:
  - lw x3,0(x2) in E, then add x4,x3,x1 in D -> StallD=1 for exactly one cycle and the next E is a bubble (ValidE=0, RegWriteE=0); the add then enters E. StallCount=1.
  - Same with an I-type using x3 only as rs2 bits -> no stall.
- Flush: FlushE=1 with a valid sw in D -> next ValidE=0, MemWriteE=0. Hazard with FlushE also set -> StallD=0.
- Hold: HoldE=1 for 3 cycles while InstrD changes -> all E outputs unchanged. HoldE=1 with FlushE=1 -> contents kept; flush applies on the first cycle after HoldE drops.
- Immediates: beq with imm -4 -> immediateE=0xFFFFFFFC, BranchE=1, ALUOpE=01. Store offset 0x7FF -> immediateE=0x000007FF. Unknown opcode 0x7F -> controls 0, immediateE=0.
